// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - RV32I opcodes, ALU/result encodings, immediate types and decode helpers
package riscv_pkg;

    localparam int XLEN     = 32;
    localparam int NUM_REGS = 32;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_LUI   = 4'd10;
    // AUIPC needs PC as operand A; Execute selects it from this code alone
    localparam logic [3:0] ALU_AUIPC = 4'd11;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_e;

    typedef struct packed {
        logic            valid;
        logic            reg_write;
        logic [1:0]      result_src;
        logic            mem_write;
        logic            jump;
        logic            branch;
        logic            alu_src;
        logic [3:0]      alu_control;
        logic [2:0]      funct3;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm_ext;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [31:0]     pc;
        logic [31:0]     next_pc;
        logic            illegal;
    } execute_t;

    function automatic logic [XLEN-1:0] imm_extend(input logic [31:0] instr, input imm_type_e t);
        case (t)
            IMM_S:   return {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   return {instr[31:12], 12'b0};
            IMM_J:   return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: return {{20{instr[31]}}, instr[31:20]};
        endcase
    endfunction

    function automatic logic [3:0] alu_decode(input logic [2:0] funct3, input logic alt);
        case (funct3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// rtl/decode_stage_if.sv - Fetch->Decode inputs and Decode->Execute pipeline outputs
interface decode_stage_if;
    import riscv_pkg::*;

    logic [31:0]     instruction_decode;
    logic [31:0]     pc_decode;
    logic [31:0]     next_pc_decode;
    logic            valid_decode;

    logic            valid_execute;
    logic            reg_write_execute;
    logic [1:0]      result_src_execute;
    logic            mem_write_execute;
    logic            jump_execute;
    logic            branch_execute;
    logic            alu_src_execute;
    logic [3:0]      alu_control_execute;
    logic [2:0]      funct3_execute;
    logic [XLEN-1:0] rd1_execute;
    logic [XLEN-1:0] rd2_execute;
    logic [XLEN-1:0] imm_ext_execute;
    logic [4:0]      rs1_execute;
    logic [4:0]      rs2_execute;
    logic [4:0]      rd_execute;
    logic [31:0]     pc_execute;
    logic [31:0]     next_pc_execute;
    logic            illegal_instr_execute;

    modport master (
        output instruction_decode, pc_decode, next_pc_decode, valid_decode,
        input  valid_execute, reg_write_execute, result_src_execute, mem_write_execute,
               jump_execute, branch_execute, alu_src_execute, alu_control_execute,
               funct3_execute, rd1_execute, rd2_execute, imm_ext_execute, rs1_execute,
               rs2_execute, rd_execute, pc_execute, next_pc_execute, illegal_instr_execute
    );

    modport slave (
        input  instruction_decode, pc_decode, next_pc_decode, valid_decode,
        output valid_execute, reg_write_execute, result_src_execute, mem_write_execute,
               jump_execute, branch_execute, alu_src_execute, alu_control_execute,
               funct3_execute, rd1_execute, rd2_execute, imm_ext_execute, rs1_execute,
               rs2_execute, rd_execute, pc_execute, next_pc_execute, illegal_instr_execute
    );

endinterface

// File: rtl/register_file.sv
// rtl/register_file.sv - 32x32 register file, 2 async reads, 1 sync write; WB_BYPASS_EN adds write-first bypass
module register_file
    import riscv_pkg::*;
#(
    parameter int AW = $clog2(NUM_REGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   raddr1,
    input  logic [AW-1:0]   raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2
);

    logic [XLEN-1:0] regs [NUM_REGS];
    logic            hit1;
    logic            hit2;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

`ifdef WB_BYPASS_EN
    assign hit1 = we && (waddr != '0) && (waddr == raddr1);
    assign hit2 = we && (waddr != '0) && (waddr == raddr2);
`else
    assign hit1 = 1'b0;
    assign hit2 = 1'b0;
`endif

    assign rdata1 = (raddr1 == '0) ? '0 : (hit1 ? wdata : regs[raddr1]);
    assign rdata2 = (raddr2 == '0) ? '0 : (hit2 ? wdata : regs[raddr2]);

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I decode stage with Decode->Execute register; WB_BYPASS_EN selects register-file bypass
module decode_stage
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    decode_stage_if.slave   bus,
    input  logic            stall_decode,
    input  logic            flush_decode,
    input  logic            reg_write_writeback,
    input  logic [4:0]      rd_writeback,
    input  logic [XLEN-1:0] result_writeback
);

    logic [31:0]     instr;
    logic [6:0]      opcode;
    logic [6:0]      funct7;
    logic [2:0]      funct3;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;

    logic            legal;
    logic            reg_write;
    logic            mem_write;
    logic            jump;
    logic            branch;
    logic            alu_src;
    logic [1:0]      result_src;
    logic [3:0]      alu_control;
    imm_type_e       imm_type;

    execute_t        ex_d;
    execute_t        ex_q;

    assign instr  = bus.instruction_decode;
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];

    register_file u_register_file (
        .clk    (clk),
        .rst    (rst),
        .we     (reg_write_writeback),
        .waddr  (rd_writeback),
        .wdata  (result_writeback),
        .raddr1 (rs1),
        .raddr2 (rs2),
        .rdata1 (rd1),
        .rdata2 (rd2)
    );

    always_comb begin
        legal       = 1'b1;
        reg_write   = 1'b0;
        mem_write   = 1'b0;
        jump        = 1'b0;
        branch      = 1'b0;
        alu_src     = 1'b0;
        result_src  = RES_ALU;
        alu_control = ALU_ADD;
        imm_type    = IMM_I;
        case (opcode)
            OP_R: begin
                reg_write   = 1'b1;
                alu_control = alu_decode(funct3, funct7[5]);
                legal       = (funct7 == 7'h00) ||
                              ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
            end
            OP_I: begin
                reg_write   = 1'b1;
                alu_src     = 1'b1;
                alu_control = alu_decode(funct3, (funct3 == 3'b101) && funct7[5]);
                if (funct3 == 3'b001)
                    legal = (funct7 == 7'h00);
                else if (funct3 == 3'b101)
                    legal = (funct7 == 7'h00) || (funct7 == 7'h20);
            end
            OP_LOAD: begin
                reg_write  = 1'b1;
                alu_src    = 1'b1;
                result_src = RES_MEM;
                legal      = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
            end
            OP_STORE: begin
                mem_write = 1'b1;
                alu_src   = 1'b1;
                imm_type  = IMM_S;
                legal     = (funct3 <= 3'b010);
            end
            OP_BRANCH: begin
                branch      = 1'b1;
                alu_control = ALU_SUB;
                imm_type    = IMM_B;
                legal       = (funct3 != 3'b010) && (funct3 != 3'b011);
            end
            OP_JAL: begin
                reg_write  = 1'b1;
                jump       = 1'b1;
                result_src = RES_PC4;
                imm_type   = IMM_J;
            end
            OP_JALR: begin
                reg_write  = 1'b1;
                jump       = 1'b1;
                alu_src    = 1'b1;
                result_src = RES_PC4;
                legal      = (funct3 == 3'b000);
            end
            OP_LUI: begin
                reg_write   = 1'b1;
                alu_src     = 1'b1;
                alu_control = ALU_LUI;
                imm_type    = IMM_U;
            end
            OP_AUIPC: begin
                reg_write   = 1'b1;
                alu_src     = 1'b1;
                alu_control = ALU_AUIPC;
                imm_type    = IMM_U;
            end
            default: legal = 1'b0;
        endcase
        // Illegal instructions still travel down the pipe but must cause no side effects
        if (!legal) begin
            reg_write = 1'b0;
            mem_write = 1'b0;
            jump      = 1'b0;
            branch    = 1'b0;
        end
    end

    always_comb begin
        ex_d             = '0;
        ex_d.valid       = 1'b1;
        ex_d.reg_write   = reg_write;
        ex_d.result_src  = result_src;
        ex_d.mem_write   = mem_write;
        ex_d.jump        = jump;
        ex_d.branch      = branch;
        ex_d.alu_src     = alu_src;
        ex_d.alu_control = alu_control;
        ex_d.funct3      = funct3;
        ex_d.rd1         = rd1;
        ex_d.rd2         = rd2;
        ex_d.imm_ext     = imm_extend(instr, imm_type);
        ex_d.rs1         = rs1;
        ex_d.rs2         = rs2;
        ex_d.rd          = rd;
        ex_d.pc          = bus.pc_decode;
        ex_d.next_pc     = bus.next_pc_decode;
        ex_d.illegal     = !legal;
    end

    always_ff @(posedge clk) begin
        if (rst || flush_decode) begin
            ex_q <= '0;
        end else if (!stall_decode) begin
            ex_q <= bus.valid_decode ? ex_d : '0;
        end
    end

    assign bus.valid_execute         = ex_q.valid;
    assign bus.reg_write_execute     = ex_q.reg_write;
    assign bus.result_src_execute    = ex_q.result_src;
    assign bus.mem_write_execute     = ex_q.mem_write;
    assign bus.jump_execute          = ex_q.jump;
    assign bus.branch_execute        = ex_q.branch;
    assign bus.alu_src_execute       = ex_q.alu_src;
    assign bus.alu_control_execute   = ex_q.alu_control;
    assign bus.funct3_execute        = ex_q.funct3;
    assign bus.rd1_execute           = ex_q.rd1;
    assign bus.rd2_execute           = ex_q.rd2;
    assign bus.imm_ext_execute       = ex_q.imm_ext;
    assign bus.rs1_execute           = ex_q.rs1;
    assign bus.rs2_execute           = ex_q.rs2;
    assign bus.rd_execute            = ex_q.rd;
    assign bus.pc_execute            = ex_q.pc;
    assign bus.next_pc_execute       = ex_q.next_pc;
    assign bus.illegal_instr_execute = ex_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - decode_stage bench: directed literals plus randomized traffic against a reference model
module tb_decode_stage;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    always #5 clk = ~clk;

    decode_stage_if bus ();

    decode_stage dut (
        .clk                 (clk),
        .rst                 (rst),
        .bus                 (bus),
        .stall_decode        (stall),
        .flush_decode        (flush),
        .reg_write_writeback (wb_we),
        .rd_writeback        (wb_rd),
        .result_writeback    (wb_data)
    );

    typedef struct {
        logic        valid, reg_write, mem_write, jump, branch, alu_src, illegal;
        logic [1:0]  result_src;
        logic [3:0]  alu_control;
        logic [2:0]  funct3;
        logic [31:0] rd1, rd2, imm, pc, next_pc;
        logic [4:0]  rs1, rs2, rd;
        bit          full;
        bit          imm_care;
    } exp_t;

    exp_t        exp_q;
    logic [31:0] mregs [32];
    int          vectors = 0;
    int          miscompares = 0;
    logic [6:0]  op_tab [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t bubble();
        exp_t e = '{default: '0};
        e.full     = 1'b1;
        e.imm_care = 1'b1;
        return e;
    endfunction

    function automatic logic [31:0] rf_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
`ifdef WB_BYPASS_EN
        if (wb_we && wb_rd == a) return wb_data;
`endif
        return mregs[a];
    endfunction

    function automatic logic [3:0] alu_of(input logic [2:0] f3, input bit alt);
        logic [3:0] base [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        if (alt && f3 == 3'd0) return ALU_SUB;
        if (alt && f3 == 3'd5) return ALU_SRA;
        return base[f3];
    endfunction

    function automatic exp_t model_decode();
        exp_t        e = '{default: '0};
        logic [31:0] ins = bus.instruction_decode;
        logic [2:0]  f3 = ins[14:12];
        logic [6:0]  f7 = ins[31:25];
        logic [31:0] i_imm = 32'($signed(ins) >>> 20);
        logic [31:0] s_imm = (32'($signed(ins) >>> 25) << 5) | 32'(ins[11:7]);
        logic [31:0] b_imm = (32'($signed(ins) >>> 31) << 12) | (32'(ins[7]) << 11) |
                             (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
        logic [31:0] u_imm = ins & 32'hFFFF_F000;
        logic [31:0] j_imm = (32'($signed(ins) >>> 31) << 20) | (32'(ins[19:12]) << 12) |
                             (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
        bit          legal = 1'b1;
        e.valid = 1'b1;  e.full = 1'b1;  e.imm_care = 1'b1;
        e.pc = bus.pc_decode;  e.next_pc = bus.next_pc_decode;
        e.rs1 = ins[19:15];  e.rs2 = ins[24:20];  e.rd = ins[11:7];  e.funct3 = f3;
        e.rd1 = rf_read(ins[19:15]);  e.rd2 = rf_read(ins[24:20]);
        case (ins[6:0])
            7'h33: begin
                legal = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
                e.reg_write = 1;  e.alu_control = alu_of(f3, f7 == 7'h20);  e.imm_care = 0;
            end
            7'h13: begin
                legal = (f3 == 1) ? (f7 == 0) : (f3 == 5) ? (f7 == 0 || f7 == 7'h20) : 1'b1;
                e.reg_write = 1;  e.alu_src = 1;  e.alu_control = alu_of(f3, f3 == 5 && f7 == 7'h20);
                e.imm = i_imm;
            end
            7'h03: begin
                legal = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
                e.reg_write = 1;  e.alu_src = 1;  e.result_src = 2'b01;  e.imm = i_imm;
            end
            7'h23: begin
                legal = f3 < 3;  e.mem_write = 1;  e.alu_src = 1;  e.imm = s_imm;
            end
            7'h63: begin
                legal = !(f3 inside {3'd2, 3'd3});  e.branch = 1;  e.alu_control = ALU_SUB;  e.imm = b_imm;
            end
            7'h6F: begin
                e.reg_write = 1;  e.jump = 1;  e.result_src = 2'b10;  e.imm = j_imm;
            end
            7'h67: begin
                legal = f3 == 0;  e.reg_write = 1;  e.jump = 1;  e.result_src = 2'b10;
                e.alu_src = 1;  e.imm = i_imm;
            end
            7'h37: begin
                e.reg_write = 1;  e.alu_src = 1;  e.alu_control = ALU_LUI;  e.imm = u_imm;
            end
            7'h17: begin
                e.reg_write = 1;  e.alu_src = 1;  e.alu_control = ALU_AUIPC;  e.imm = u_imm;
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            e.illegal = 1;  e.reg_write = 0;  e.mem_write = 0;  e.jump = 0;  e.branch = 0;
            e.full = 0;
        end
        return e;
    endfunction

    task automatic compare_all();
        chk("valid", bus.valid_execute, exp_q.valid);
        chk("reg_write", bus.reg_write_execute, exp_q.reg_write);
        chk("mem_write", bus.mem_write_execute, exp_q.mem_write);
        chk("jump", bus.jump_execute, exp_q.jump);
        chk("branch", bus.branch_execute, exp_q.branch);
        chk("illegal", bus.illegal_instr_execute, exp_q.illegal);
        if (exp_q.full) begin
            chk("result_src", bus.result_src_execute, exp_q.result_src);
            chk("alu_src", bus.alu_src_execute, exp_q.alu_src);
            chk("alu_control", bus.alu_control_execute, exp_q.alu_control);
            chk("funct3", bus.funct3_execute, exp_q.funct3);
            chk("rd1", bus.rd1_execute, exp_q.rd1);
            chk("rd2", bus.rd2_execute, exp_q.rd2);
            chk("rs1", bus.rs1_execute, exp_q.rs1);
            chk("rs2", bus.rs2_execute, exp_q.rs2);
            chk("rd", bus.rd_execute, exp_q.rd);
            chk("pc", bus.pc_execute, exp_q.pc);
            chk("next_pc", bus.next_pc_execute, exp_q.next_pc);
            if (exp_q.imm_care) chk("imm_ext", bus.imm_ext_execute, exp_q.imm);
        end
    endtask

    // One clock: predict, advance model at the edge, then compare on the falling edge
    task automatic step();
        exp_t nxt;
        if (rst || flush)      nxt = bubble();
        else if (stall)        nxt = exp_q;
        else if (!bus.valid_decode) nxt = bubble();
        else                   nxt = model_decode();
        @(posedge clk);
        exp_q = nxt;
        if (rst) begin
            for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
        end else if (wb_we && wb_rd != 5'd0) begin
            mregs[wb_rd] = wb_data;
        end
        @(negedge clk);
        compare_all();
    endtask

    task automatic issue(input logic [31:0] ins, input logic [31:0] pc);
        bus.instruction_decode = ins;
        bus.pc_decode          = pc;
        bus.next_pc_decode     = pc + 32'd4;
        bus.valid_decode       = 1'b1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins = $urandom;
        if ($urandom_range(0, 9) != 0) begin
            ins[6:0] = op_tab[$urandom_range(0, 8)];
            if ($urandom_range(0, 3) != 0) ins[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
        end
        return ins;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [4:0]  a;
        logic [4:0]  b;
        logic [31:0] bypass_exp;
        for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
        exp_q = bubble();
        rst = 1'b1;  stall = 1'b0;  flush = 1'b0;
        wb_we = 1'b0;  wb_rd = 5'd0;  wb_data = 32'd0;
        issue(32'h0010_8133, 32'h0000_0100);
        step();
        step();
        chk("rst_valid", bus.valid_execute, 32'd0);
        chk("rst_pc", bus.pc_execute, 32'd0);
        chk("rst_alu_control", bus.alu_control_execute, 32'd0);
        rst = 1'b0;

        for (int i = 1; i < 32; i += 2) begin
            a = 5'(i);
            b = 5'(i + 1);
            issue({7'd0, b, a, 3'd0, 5'd0, 7'h33}, 32'h200 + 32'(i) * 4);
            step();
            chk("rf_clear_rd1", bus.rd1_execute, 32'd0);
            chk("rf_clear_rd2", bus.rd2_execute, 32'd0);
        end

        issue(32'h0050_0093, 32'h0000_0300);
        step();
        chk("addi_imm", bus.imm_ext_execute, 32'd5);
        chk("addi_rd", bus.rd_execute, 32'd1);
        chk("addi_reg_write", bus.reg_write_execute, 32'd1);
        chk("addi_alu_src", bus.alu_src_execute, 32'd1);
        chk("addi_result_src", bus.result_src_execute, 32'd0);
        chk("addi_valid", bus.valid_execute, 32'd1);

`ifdef WB_BYPASS_EN
        bypass_exp = 32'hDEAD_BEEF;
`else
        bypass_exp = 32'h0000_0000;
`endif
        wb_we = 1'b1;  wb_rd = 5'd1;  wb_data = 32'hDEAD_BEEF;
        issue(32'h0010_8133, 32'h0000_0304);
        step();
        chk("same_cycle_rd1", bus.rd1_execute, bypass_exp);
        chk("same_cycle_rd2", bus.rd2_execute, bypass_exp);
        wb_we = 1'b0;
        step();
        chk("after_write_rd1", bus.rd1_execute, 32'hDEAD_BEEF);
        wb_we = 1'b1;  wb_rd = 5'd0;  wb_data = 32'h0000_1234;
        issue(32'h0000_0133, 32'h0000_0308);
        step();
        chk("x0_same_cycle", bus.rd1_execute, 32'd0);
        wb_we = 1'b0;
        step();
        chk("x0_after_write", bus.rd2_execute, 32'd0);

        issue(32'hFE00_0EE3, 32'h0000_0400);
        step();
        chk("beq_branch", bus.branch_execute, 32'd1);
        chk("beq_imm", bus.imm_ext_execute, 32'hFFFF_FFFC);
        chk("beq_reg_write", bus.reg_write_execute, 32'd0);
        flush = 1'b1;
        step();
        chk("flush_valid", bus.valid_execute, 32'd0);
        flush = 1'b0;

        issue(32'h0050_0093, 32'h0000_0500);
        step();
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            issue(rand_instr(), 32'h0000_0600 + 32'(k) * 4);
            step();
            chk("stall_hold_imm", bus.imm_ext_execute, 32'd5);
            chk("stall_hold_pc", bus.pc_execute, 32'h0000_0500);
            chk("stall_hold_valid", bus.valid_execute, 32'd1);
        end
        flush = 1'b1;
        step();
        chk("stall_flush_valid", bus.valid_execute, 32'd0);
        stall = 1'b0;  flush = 1'b0;

        issue(32'hFFFF_FFFF, 32'h0000_0700);
        step();
        chk("illegal_flag", bus.illegal_instr_execute, 32'd1);
        chk("illegal_valid", bus.valid_execute, 32'd1);
        chk("illegal_reg_write", bus.reg_write_execute, 32'd0);
        chk("illegal_mem_write", bus.mem_write_execute, 32'd0);
        chk("illegal_jump", bus.jump_execute, 32'd0);
        chk("illegal_branch", bus.branch_execute, 32'd0);

        for (int n = 0; n < 3000; n++) begin
            issue(rand_instr(), $urandom & 32'hFFFF_FFFC);
            bus.valid_decode = ($urandom_range(0, 7) != 0);
            stall   = ($urandom_range(0, 4) == 0);
            flush   = ($urandom_range(0, 9) == 0);
            rst     = ($urandom_range(0, 499) == 0);
            wb_we   = ($urandom_range(0, 1) != 0);
            wb_rd   = ($urandom_range(0, 3) == 0) ? bus.instruction_decode[19:15] : 5'($urandom);
            wb_data = $urandom;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
